imm_instr_encoder: RTL and testbench

- Inverse of the immediate-extraction path: takes opcode, immediate class, signed 8-bit immediate and a base word with register fields, and packs them into a 16-bit instruction.
- Range-checks each immediate so that decoding the packed word reproduces the requested immediate exactly.
- Streams packed words into instruction memory at auto-incrementing addresses; used by the program loader and the self-test sequencer.

---
 rtl/imm_instr_encoder_pkg.sv | 31 +++
 rtl/imm_instr_encoder_imm_field_packer.sv | 56 +++++
 rtl/imm_instr_encoder.sv | 160 ++++++++++++++++
 tb/tb_imm_instr_encoder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_instr_encoder_pkg.sv
// ---------------------------------------------------------------------------
// imm_instr_encoder_pkg
// Shared definitions for the immediate instruction encoder:
//   - opcode constants for the class-00 instructions (JMP, LDI)
//   - immediate class constants (imm_src encodings)
//   - error codes reported on err_code
//   - the loader FSM state enum
// ---------------------------------------------------------------------------
package imm_instr_encoder_pkg;

  localparam logic [3:0] OP_JMP   = 4'b1010;
  localparam logic [3:0] OP_LDI   = 4'b1101;

  localparam logic [1:0] IMM_J_L  = 2'b00;
  localparam logic [1:0] IMM_MEM  = 2'b01;
  localparam logic [1:0] IMM_SH   = 2'b10;
  localparam logic [1:0] IMM_ADDI = 2'b11;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_OPC   = 2'b10;
  localparam logic [1:0] ERR_OVF   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_WRITE = 2'b10,
    ST_ERR   = 2'b11
  } state_t;

endpackage

// File: rtl/imm_instr_encoder_imm_field_packer.sv
// ---------------------------------------------------------------------------
// imm_field_packer
// Purely combinational: merges opcode and immediate into a base word and
// reports whether the immediate survives a decode round-trip.
// Ports:
//   opcode       in  [3:0]  placed at word[15:12]
//   imm_src      in  [1:0]  immediate class
//   imm_in       in  [7:0]  signed immediate
//   base_word    in  [15:0] register/other fields
//   word_out     out [15:0] packed instruction
//   err_code_out out [1:0]  ERR_NONE, ERR_RANGE or ERR_OPC
// ---------------------------------------------------------------------------
module imm_field_packer
  import imm_instr_encoder_pkg::*;
(
  input  logic        [3:0]  opcode,
  input  logic        [1:0]  imm_src,
  input  logic signed [7:0]  imm_in,
  input  logic        [15:0] base_word,
  output logic        [15:0] word_out,
  output logic        [1:0]  err_code_out
);

  always_comb begin
    word_out         = base_word;
    word_out[15:12]  = opcode;
    err_code_out     = ERR_NONE;
    case (imm_src)
      IMM_J_L: begin
        if (opcode == OP_JMP) begin
          word_out[8:1] = imm_in;
        end else if (opcode == OP_LDI) begin
          word_out[11:4] = imm_in;
        end else begin
          err_code_out = ERR_OPC;
        end
      end
      IMM_MEM: begin
        // 6-bit signed field: the top three bits must all match the field sign.
        word_out[5:0] = imm_in[5:0];
        if (imm_in[7:5] != {3{imm_in[5]}}) err_code_out = ERR_RANGE;
      end
      IMM_SH: begin
        word_out[5:3] = imm_in[2:0];
        if (imm_in[7:3] != 5'd0) err_code_out = ERR_RANGE;
      end
      default: begin
        // ADDI: the decoder sign-extends from word bit 1 (imm_in[0]), so
        // imm_in[7:5] must replicate imm_in[0] to round-trip.
        word_out[5:1] = imm_in[4:0];
        if (imm_in[7:5] != {3{imm_in[0]}}) err_code_out = ERR_RANGE;
      end
    endcase
  end

endmodule

// File: rtl/imm_instr_encoder.sv
// ---------------------------------------------------------------------------
// imm_instr_encoder
// Packs opcode/immediate field bundles into 16-bit instructions and streams
// them into instruction memory at auto-incrementing addresses.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, start_addr   begin a load session at start_addr (IDLE/ERR only)
//   s_valid/s_ready     field bundle handshake; s_last marks final word
//   opcode, imm_src, imm_in, base_word   field bundle
//   mem_we, mem_addr, mem_wdata          instruction memory write port
//   done                one-cycle pulse after the last word is written
//   err, err_code       sticky error and its cause
//   word_count          words written this session
// ---------------------------------------------------------------------------
module imm_instr_encoder
  import imm_instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  input  logic [3:0]        opcode,
  input  logic [1:0]        imm_src,
  input  logic [7:0]        imm_in,
  input  logic [15:0]       base_word,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         mem_wdata_q, mem_wdata_d;
  logic                done_q, done_d;
  logic                last_q, last_d;

  logic signed [7:0]   imm_s;
  logic [15:0]         packed_word;
  logic [1:0]          pack_err;

  assign imm_s = imm_in;

  imm_field_packer u_packer (
    .opcode       (opcode),
    .imm_src      (imm_src),
    .imm_in       (imm_s),
    .base_word    (base_word),
    .word_out     (packed_word),
    .err_code_out (pack_err)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    done_d       = 1'b0;
    last_d       = last_q;

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_d      = ST_RUN;
          addr_d       = start_addr;
          word_count_d = '0;
          err_d        = 1'b0;
          err_code_d   = ERR_NONE;
        end
      end
      ST_RUN: begin
        if (s_valid) begin
          if (pack_err != ERR_NONE) begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            err_code_d = pack_err;
          end else begin
            state_d     = ST_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = packed_word;
            last_d      = s_last;
          end
        end
      end
      ST_WRITE: begin
        word_count_d = word_count_q + 1'b1;
        // Address saturates at the top of memory instead of wrapping.
        if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
        if (last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (addr_q == LAST_ADDR) begin
          state_d    = ST_ERR;
          err_d      = 1'b1;
          err_code_d = ERR_OVF;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      word_count_q <= '0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      done_q       <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      done_q       <= done_d;
      last_q       <= last_d;
    end
  end

  assign s_ready    = (state_q == ST_RUN);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_imm_instr_encoder
// Directed scenarios plus randomized sessions for imm_instr_encoder, checked
// against a decode-round-trip reference model.
// ---------------------------------------------------------------------------
module tb_imm_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  start_addr = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_last = 1'b0;
  logic [3:0]  opcode = '0;
  logic [1:0]  imm_src = '0;
  logic [7:0]  imm_in = '0;
  logic [15:0] base_word = '0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [8:0]  word_count;

  int tests_run = 0;
  int tests_failed = 0;

  imm_instr_encoder #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .opcode(opcode), .imm_src(imm_src), .imm_in(imm_in), .base_word(base_word),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .err(err), .err_code(err_code), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Reference: build the word, then accept the immediate only if the value a
  // decoder would recover from the packed field equals the requested value.
  function automatic void ref_encode(input logic [3:0] op, input logic [1:0] src,
                                     input logic [7:0] imm, input logic [15:0] base,
                                     output logic [15:0] w, output logic [1:0] code);
    int v;
    int dec;
    v = int'(imm);
    if (v > 127) v = v - 256;
    w = {op, base[11:0]};
    code = 2'd0;
    case (src)
      2'd0: begin
        if (op == 4'hA)      w = (w & 16'hFE01) | (16'(imm) << 1);
        else if (op == 4'hD) w = (w & 16'hF00F) | (16'(imm) << 4);
        else                 code = 2'd2;
      end
      2'd1: begin
        if (v < -32 || v > 31) code = 2'd1;
        else w = (w & 16'hFFC0) | 16'(v & 63);
      end
      2'd2: begin
        if (v < 0 || v > 7) code = 2'd1;
        else w = (w & 16'hFFC7) | 16'(v << 3);
      end
      default: begin
        dec = (v & 31) - (((v & 1) != 0) ? 32 : 0);
        if (dec != v) code = 2'd1;
        else w = (w & 16'hFFC1) | 16'((v & 31) << 1);
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [7:0] a);
    start = 1'b1; start_addr = a;
    tick();
    start = 1'b0;
  endtask

  // Presents one bundle; returns once it is taken (ok=1) or after 10 cycles.
  task automatic drive_bundle(input logic [3:0] op, input logic [1:0] src,
                              input logic [7:0] imm, input logic [15:0] base,
                              input logic last, output logic ok);
    ok = 1'b0;
    opcode = op; imm_src = src; imm_in = imm; base_word = base; s_last = last;
    s_valid = 1'b1;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (s_ready === 1'b1) ok = 1'b1;
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    tests_run++; if (mem_we !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin tests_failed++; $display("FAIL reset_ctrl we=%b done=%b err=%b want 000", mem_we, done, err); end
    tests_run++; if (word_count !== 9'd0 || err_code !== 2'd0 || s_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_state wc=%0d code=%0d rdy=%b want 0 0 0", word_count, err_code, s_ready); end
    tests_run++; if (mem_addr !== 8'd0 || mem_wdata !== 16'd0) begin tests_failed++; $display("FAIL reset_data addr=%h wdata=%h want 0 0", mem_addr, mem_wdata); end
    @(negedge clk); rst = 1'b0;
    tick();
    // s_valid while idle must not be taken
    s_valid = 1'b1; opcode = 4'h4; imm_src = 2'd1; imm_in = 8'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (s_ready !== 1'b0 || mem_we !== 1'b0) begin tests_failed++; $display("FAIL idle_ignore rdy=%b we=%b want 0 0", s_ready, mem_we); end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_single_mem();
    logic ok;
    do_start(8'h10);
    tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL run_ready got %b want 1", s_ready); end
    drive_bundle(4'h4, 2'd1, 8'hFB, 16'h0000, 1'b1, ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL single_accept timeout"); end
    tests_run++; if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 16'h403B) begin tests_failed++; $display("FAIL single_write we=%b addr=%h wdata=%h want 1 10 403B", mem_we, mem_addr, mem_wdata); end
    tests_run++; if (s_ready !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL single_write_ctl rdy=%b done=%b want 0 0", s_ready, done); end
    tick();
    tests_run++; if (done !== 1'b1 || mem_we !== 1'b0 || word_count !== 9'd1) begin tests_failed++; $display("FAIL single_done done=%b we=%b wc=%0d want 1 0 1", done, mem_we, word_count); end
    tick();
    tests_run++; if (done !== 1'b0 || s_ready !== 1'b0) begin tests_failed++; $display("FAIL single_pulse done=%b rdy=%b want 0 0", done, s_ready); end
  endtask

  task automatic test_ldi_jmp();
    logic ok;
    do_start(8'h20);
    drive_bundle(4'hD, 2'd0, 8'h7F, 16'h000E, 1'b0, ok);
    tests_run++; if (ok !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 16'hD7FE) begin tests_failed++; $display("FAIL ldi_write ok=%b we=%b addr=%h wdata=%h want 1 1 20 D7FE", ok, mem_we, mem_addr, mem_wdata); end
    tick();
    tests_run++; if (done !== 1'b0 || s_ready !== 1'b1 || word_count !== 9'd1) begin tests_failed++; $display("FAIL ldi_next done=%b rdy=%b wc=%0d want 0 1 1", done, s_ready, word_count); end
    drive_bundle(4'hA, 2'd0, 8'h81, 16'h0000, 1'b1, ok);
    tests_run++; if (ok !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h21 || mem_wdata !== 16'hA102) begin tests_failed++; $display("FAIL jmp_write ok=%b we=%b addr=%h wdata=%h want 1 1 21 A102", ok, mem_we, mem_addr, mem_wdata); end
    tick();
    tests_run++; if (done !== 1'b1 || word_count !== 9'd2) begin tests_failed++; $display("FAIL jmp_done done=%b wc=%0d want 1 2", done, word_count); end
  endtask

  task automatic test_range_err();
    logic ok;
    do_start(8'h30);
    drive_bundle(4'h4, 2'd1, 8'd32, 16'h0000, 1'b0, ok);
    tests_run++; if (ok !== 1'b1 || mem_we !== 1'b0 || err !== 1'b1 || err_code !== 2'b01) begin tests_failed++; $display("FAIL mem_range ok=%b we=%b err=%b code=%b want 1 0 1 01", ok, mem_we, err, err_code); end
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (s_ready !== 1'b0 || mem_we !== 1'b0 || err !== 1'b1) begin tests_failed++; $display("FAIL err_hold rdy=%b we=%b err=%b want 0 0 1", s_ready, mem_we, err); end
    end
    s_valid = 1'b0;
    do_start(8'h30);
    tests_run++; if (err !== 1'b0 || err_code !== 2'b00 || s_ready !== 1'b1) begin tests_failed++; $display("FAIL err_clear err=%b code=%b rdy=%b want 0 00 1", err, err_code, s_ready); end
    drive_bundle(4'h3, 2'd0, 8'h05, 16'h0000, 1'b1, ok);
    tests_run++; if (mem_we !== 1'b0 || err !== 1'b1 || err_code !== 2'b10) begin tests_failed++; $display("FAIL bad_opc we=%b err=%b code=%b want 0 1 10", mem_we, err, err_code); end
    do_start(8'h30);
    drive_bundle(4'h6, 2'd2, 8'd8, 16'h0000, 1'b1, ok);
    tests_run++; if (mem_we !== 1'b0 || err_code !== 2'b01) begin tests_failed++; $display("FAIL shift_range we=%b code=%b want 0 01", mem_we, err_code); end
  endtask

  task automatic test_addi();
    logic ok;
    do_start(8'h40);
    drive_bundle(4'h5, 2'd3, 8'h03, 16'h0000, 1'b1, ok);
    tests_run++; if (mem_we !== 1'b0 || err !== 1'b1 || err_code !== 2'b01) begin tests_failed++; $display("FAIL addi_range we=%b err=%b code=%b want 0 1 01", mem_we, err, err_code); end
    do_start(8'h40);
    drive_bundle(4'h5, 2'd3, 8'hEB, 16'h0000, 1'b1, ok);
    tests_run++; if (mem_we !== 1'b1 || mem_wdata[5:1] !== 5'b01011 || mem_wdata !== 16'h5016) begin tests_failed++; $display("FAIL addi_pack we=%b wdata=%h want 1 5016", mem_we, mem_wdata); end
    tick();
  endtask

  task automatic test_overflow();
    logic ok;
    do_start(8'hFF);
    drive_bundle(4'h4, 2'd1, 8'h01, 16'h0000, 1'b0, ok);
    tests_run++; if (mem_we !== 1'b1 || mem_addr !== 8'hFF) begin tests_failed++; $display("FAIL ovf_write we=%b addr=%h want 1 FF", mem_we, mem_addr); end
    tick();
    tests_run++; if (err !== 1'b1 || err_code !== 2'b11 || done !== 1'b0 || word_count !== 9'd1) begin tests_failed++; $display("FAIL ovf_err err=%b code=%b done=%b wc=%0d want 1 11 0 1", err, err_code, done, word_count); end
    drive_bundle(4'h4, 2'd1, 8'h02, 16'h0000, 1'b0, ok);
    tests_run++; if (ok !== 1'b0 || mem_we !== 1'b0 || s_ready !== 1'b0) begin tests_failed++; $display("FAIL ovf_block ok=%b we=%b rdy=%b want 0 0 0", ok, mem_we, s_ready); end
  endtask

  task automatic test_reset_mid_write();
    logic ok;
    do_start(8'h50);
    drive_bundle(4'h4, 2'd1, 8'h01, 16'h0000, 1'b0, ok);
    tick();
    drive_bundle(4'h4, 2'd1, 8'h02, 16'h0000, 1'b1, ok);
    tests_run++; if (mem_we !== 1'b1 || word_count !== 9'd1) begin tests_failed++; $display("FAIL pre_rst we=%b wc=%0d want 1 1", mem_we, word_count); end
    rst = 1'b1;
    #1;
    tests_run++; if (mem_we !== 1'b0 || done !== 1'b0 || err !== 1'b0 || word_count !== 9'd0) begin tests_failed++; $display("FAIL async_rst we=%b done=%b err=%b wc=%0d want 0 0 0 0", mem_we, done, err, word_count); end
    @(negedge clk); rst = 1'b0;
    tick();
    tests_run++; if (s_ready !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0) begin tests_failed++; $display("FAIL post_rst rdy=%b done=%b we=%b want 0 0 0", s_ready, done, mem_we); end
  endtask

  task automatic test_random();
    logic ok;
    logic [3:0] op;
    logic [1:0] src;
    logic [7:0] imm;
    logic [15:0] base, exp_w;
    logic [1:0] exp_c;
    logic [7:0] a;
    int len;
    for (int s = 0; s < 12; s++) begin
      a = 8'($urandom_range(0, 200));
      len = int'($urandom_range(1, 5));
      do_start(a);
      for (int k = 0; k < len; k++) begin
        src = 2'($urandom_range(0, 3));
        op = 4'($urandom_range(0, 15));
        if (src == 2'd0 && $urandom_range(0, 9) < 8) op = ($urandom_range(0, 1) != 0) ? 4'hA : 4'hD;
        imm = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 9) < 6) begin
          case (src)
            2'd1: imm = 8'(int'($urandom_range(0, 63)) - 32);
            2'd2: imm = 8'($urandom_range(0, 7));
            2'd3: imm = ($urandom_range(0, 1) != 0) ? (8'hE1 | 8'($urandom_range(0, 15) << 1)) : 8'($urandom_range(0, 15) << 1);
            default: ;
          endcase
        end
        base = 16'($urandom_range(0, 65535));
        ref_encode(op, src, imm, base, exp_w, exp_c);
        drive_bundle(op, src, imm, base, (k == len - 1), ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL rnd_accept s=%0d k=%0d timeout", s, k); end
        if (exp_c != 2'd0) begin
          tests_run++; if (mem_we !== 1'b0 || err !== 1'b1 || err_code !== exp_c) begin tests_failed++; $display("FAIL rnd_err src=%0d op=%h imm=%h we=%b err=%b code=%0d want 0 1 %0d", src, op, imm, mem_we, err, err_code, exp_c); end
          break;
        end
        tests_run++; if (mem_we !== 1'b1 || mem_addr !== 8'(a + 8'(k)) || mem_wdata !== exp_w) begin tests_failed++; $display("FAIL rnd_write src=%0d op=%h imm=%h base=%h we=%b addr=%h wdata=%h want 1 %h %h", src, op, imm, base, mem_we, mem_addr, mem_wdata, 8'(a + 8'(k)), exp_w); end
        tick();
        tests_run++; if (done !== (k == len - 1) || word_count !== 9'(k + 1)) begin tests_failed++; $display("FAIL rnd_after done=%b wc=%0d want %0d %0d", done, word_count, (k == len - 1), k + 1); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_mem();
    test_ldi_jmp();
    test_range_err();
    test_addi();
    test_overflow();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
